// File: rtl/multiport_register_file_pkg.sv
// Shared defaults and types for the ARM core register file.
// The top module exposes these defaults as overridable parameters.
package arm_rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_NUM_RD   = 3;
    localparam int RF_PC_IDX   = 15;
    localparam int RF_PC_INC   = 4;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

    typedef logic [RF_DATA_W-1:0] rf_word_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/multiport_register_file_cell.sv
// One register word: load-enabled flop with asynchronous active-low clear.
module register_cell
    import arm_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              LE,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_q <= '0;
        end else if (LE) begin
            r_q <= D;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/multiport_register_file.sv
// Register file with NUM_RD async read ports, two write ports, write-through
// bypass and an auto-incrementing program counter held at R[PC_IDX].
module multiport_register_file
    import arm_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int PC_IDX = RF_PC_IDX,
    parameter int PC_INC = RF_PC_INC
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     pc_inc,
    input  logic                     pc_ld,
    input  logic [DATA_W-1:0]        pc_in,
    output logic [DATA_W-1:0]        pc_out,
    output logic                     wr_conf
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PC_STEP  = DATA_W'(PC_INC);

    // While CLR is low nothing is written and nothing is bypassed, so every
    // read port shows the cleared state immediately.
    logic w_we0, w_we1, w_pc_ld, w_pc_inc;
    assign w_we0    = we0    & CLR;
    assign w_we1    = we1    & CLR;
    assign w_pc_ld  = pc_ld  & CLR;
    assign w_pc_inc = pc_inc & CLR;

    logic [DATA_W-1:0] w_q [NUM_REGS];

    logic              w_pc_hit0, w_pc_hit1, w_pc_le;
    logic [DATA_W-1:0] w_pc_d;
    assign w_pc_hit0 = w_we0 && (wa0 == PC_A);
    assign w_pc_hit1 = w_we1 && (wa1 == PC_A);
    assign w_pc_le   = w_pc_hit0 | w_pc_hit1 | w_pc_ld | w_pc_inc;

    always_comb begin
        if (w_pc_hit0) begin
            w_pc_d = wd0;
        end else if (w_pc_hit1) begin
            w_pc_d = wd1;
        end else if (w_pc_ld) begin
            w_pc_d = pc_in;
        end else begin
            w_pc_d = w_q[PC_IDX] + PC_STEP;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] A = ADDR_W'(gi);
            logic              w_le;
            logic [DATA_W-1:0] w_d;

            if (gi == PC_IDX) begin : g_pc
                assign w_le = w_pc_le;
                assign w_d  = w_pc_d;
            end else begin : g_gp
                logic w_hit0, w_hit1;
                assign w_hit0 = w_we0 && (wa0 == A);
                assign w_hit1 = w_we1 && (wa1 == A);
                assign w_le   = w_hit0 | w_hit1;
                // Port 0 wins a same-address conflict.
                assign w_d    = w_hit0 ? wd0 : wd1;
            end

            register_cell #(.DATA_W(DATA_W)) R (
                .CLK (CLK),
                .CLR (CLR),
                .LE  (w_le),
                .D   (w_d),
                .Q   (w_q[gi])
            );
        end

        // pc_inc is deliberately not bypassed: operands see the pre-increment PC.
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;
            assign w_ra = rd_addr[gi*ADDR_W +: ADDR_W];
            assign w_rd = (w_we0 && (wa0 == w_ra))     ? wd0   :
                          (w_we1 && (wa1 == w_ra))     ? wd1   :
                          (w_pc_ld && (w_ra == PC_A))  ? pc_in :
                                                         w_q[w_ra];
            assign rd_data[gi*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

    logic r_wr_conf;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_wr_conf <= 1'b0;
        end else begin
            r_wr_conf <= we0 & we1 & (wa0 == wa1);
        end
    end

    assign wr_conf = r_wr_conf;
    assign pc_out  = w_q[PC_IDX];

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: directed scenarios plus random traffic.
module tb_multiport_register_file;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NR   = 3;
    localparam int NREG = 16;
    localparam int PCI  = 15;

    logic              CLK = 1'b0;
    logic              CLR = 1'b0;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR*DW-1:0]  rd_data;
    logic              we0 = 1'b0, we1 = 1'b0, pc_inc = 1'b0, pc_ld = 1'b0;
    logic [AW-1:0]     wa0 = '0, wa1 = '0;
    logic [DW-1:0]     wd0 = '0, wd1 = '0, pc_in = '0;
    logic [DW-1:0]     pc_out;
    logic              wr_conf;

    multiport_register_file dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .pc_inc  (pc_inc),
        .pc_ld   (pc_ld),
        .pc_in   (pc_in),
        .pc_out  (pc_out),
        .wr_conf (wr_conf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NR*DW-1:0] rd;
        logic [DW-1:0]    pc;
        logic             conf;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_reg [NREG];
    logic          m_conf = 1'b0;
    int            checks = 0;
    int            errors = 0;

    // Architectural view: a write or branch issued this cycle is already visible to readers.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (!CLR)                      return '0;
        if (we0 && wa0 == a)           return wd0;
        if (we1 && wa1 == a)           return wd1;
        if (pc_ld && a == AW'(PCI))    return pc_in;
        return m_reg[a];
    endfunction

    task automatic step();
        exp_t          e;
        logic [DW-1:0] nxt [NREG];
        logic          nconf;
        if (!CLR) begin
            foreach (m_reg[i]) m_reg[i] = '0;
            m_conf = 1'b0;
        end
        for (int k = 0; k < NR; k++)
            e.rd[k*DW +: DW] = model_read(rd_addr[k*AW +: AW]);
        e.pc   = m_reg[PCI];
        e.conf = m_conf;
        sb.push_back(e);

        nxt = m_reg;
        if (we1) nxt[wa1] = wd1;
        if (we0) nxt[wa0] = wd0;
        if (!(we0 && wa0 == AW'(PCI)) && !(we1 && wa1 == AW'(PCI))) begin
            if (pc_ld)       nxt[PCI] = pc_in;
            else if (pc_inc) nxt[PCI] = m_reg[PCI] + 32'd4;
        end
        nconf = we0 && we1 && (wa0 == wa1);

        @(posedge CLK);
        #1;
        if (CLR) begin
            m_reg  = nxt;
            m_conf = nconf;
        end
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; pc_inc = 1'b0; pc_ld = 1'b0;
    endtask

    task automatic set_rd(input int a, input int b, input int c);
        rd_addr = {AW'(c), AW'(b), AW'(a)};
    endtask

    exp_t me;
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            for (int k = 0; k < NR; k++) begin
                checks++;
                if (rd_data[k*DW +: DW] !== me.rd[k*DW +: DW]) begin
                    errors++;
                    $display("FAIL rd_data[%0d] t=%0t addr=%0d got %h expected %h", k, $time,
                             rd_addr[k*AW +: AW], rd_data[k*DW +: DW], me.rd[k*DW +: DW]);
                end
            end
            checks++;
            if (pc_out !== me.pc) begin
                errors++;
                $display("FAIL pc_out t=%0t got %h expected %h", $time, pc_out, me.pc);
            end
            checks++;
            if (wr_conf !== me.conf) begin
                errors++;
                $display("FAIL wr_conf t=%0t got %b expected %b", $time, wr_conf, me.conf);
            end
        end
    end

    initial begin
        foreach (m_reg[i]) m_reg[i] = '0;
        @(posedge CLK);
        #1;

        // Reset held with a write pending: nothing may be written or bypassed.
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            set_rd(3, i, 15);
            step();
        end
        idle();
        CLR = 1'b1;
        set_rd(3, 0, 15);
        step();

        // Same-cycle bypass, then registered value.
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'h1234_5678;
        set_rd(3, 4, 15);
        step();
        idle();
        step();

        // Same-address conflict: port 0 wins, flag pulses for one cycle.
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'hAAAA_0000;
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h0000_BBBB;
        set_rd(5, 3, 15);
        step();
        idle();
        step();
        step();

        // PC increments, then wrap at the top of the address space.
        pc_inc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle();
        pc_ld = 1'b1; pc_in = 32'hFFFF_FFFC;
        step();
        idle();
        pc_inc = 1'b1;
        step();
        idle();
        step();

        // Priority: base writeback beats branch beats increment; then a plain branch.
        pc_ld = 1'b1; pc_in = 32'h0000_8000; pc_inc = 1'b1;
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h0000_0100;
        set_rd(15, 15, 5);
        step();
        idle();
        pc_ld = 1'b1;
        step();
        idle();
        step();

        // Fill every register, then sweep three ports with a reset in the middle.
        for (int i = 0; i < NREG; i++) begin
            we0 = 1'b1; wa0 = AW'(i); wd0 = 32'h1000 + i;
            set_rd(i, (i + 15) % 16, (i + 14) % 16);
            step();
        end
        idle();
        for (int i = 0; i < NREG; i++) begin
            set_rd(i, (i + 15) % 16, (i + 14) % 16);
            CLR = (i != 9);
            step();
        end
        CLR = 1'b1;

        // Random traffic with frequent conflicts and occasional resets.
        for (int n = 0; n < 400; n++) begin
            CLR    = ($urandom_range(0, 40) != 0);
            we0    = $urandom_range(0, 1);
            we1    = $urandom_range(0, 1);
            wa0    = AW'($urandom_range(0, 15));
            wa1    = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, 15));
            wd0    = $urandom;
            wd1    = $urandom;
            pc_ld  = ($urandom_range(0, 5) == 0);
            pc_inc = $urandom_range(0, 1);
            pc_in  = $urandom;
            rd_addr = NR*AW'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wa0;
            step();
        end
        CLR = 1'b1;
        idle();

        for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge CLK);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
